// File: rtl/reg2apb_mst_pkg.sv
// Shared register-interface definitions for the register-to-APB bridge:
// state encoding, timeout response pattern and default timeout length.
package reg2apb_mst_pkg;

  // Two-bit state encoding. These are plain constants so that older code
  // comparing raw state values keeps working.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Read data returned when the completer never raises PREADY.
  localparam logic [31:0] TIMEOUT_PATTERN = 32'hdead_1eaf;

  // Default number of ACCESS wait cycles tolerated before aborting.
  localparam int TIMECNT_DEFAULT = 99;

endpackage

// File: rtl/reg2apb_mst.sv
// Register-request to APB3 master bridge. One transfer at a time:
// IDLE accepts a request, SETUP/ACCESS run the APB phases, RESP holds
// the response until upstream takes it. A watchdog aborts transfers
// whose completer stalls too long.
module reg2apb_mst
  import reg2apb_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TIMECNT    = TIMECNT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rstn,
  // upstream request
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  sync_reset,
  // upstream response
  output logic                  ack_vld,
  input  logic                  ack_rdy,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  ack_err,
  // APB3 master
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  logic [1:0]  state_reg;
  logic [15:0] cnt_reg;

  // Handshake flags are pure state decodes.
  assign req_rdy = (state_reg == ST_IDLE);
  assign ack_vld = (state_reg == ST_RESP);

  // Transfer sequencer: state, APB drive, wait counter and response capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWDATA    <= '0;
      rd_data   <= '0;
      ack_err   <= 1'b0;
    end else if (sync_reset) begin
      // Upstream abort wins over everything, including a completing PREADY.
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_vld) begin
            if (wr_en ^ rd_en) begin
              PADDR     <= addr;
              PWDATA    <= wr_data;
              PWRITE    <= wr_en;
              PSEL      <= 1'b1;
              PENABLE   <= 1'b0;
              cnt_reg   <= '0;
              state_reg <= ST_SETUP;
            end else begin
              // Neither or both directions requested: reject without a bus cycle.
              rd_data   <= '0;
              ack_err   <= 1'b1;
              state_reg <= ST_RESP;
            end
          end
        end
        ST_SETUP: begin
          PENABLE   <= 1'b1;
          state_reg <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            // A PREADY arriving on the last allowed cycle still completes.
            rd_data   <= PWRITE ? '0 : PRDATA;
            ack_err   <= PSLVERR;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state_reg <= ST_RESP;
          end else if (cnt_reg == 16'(TIMECNT)) begin
            rd_data   <= DATA_WIDTH'(TIMEOUT_PATTERN);
            ack_err   <= 1'b1;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            state_reg <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: begin
          // ST_RESP: response registers hold until upstream accepts.
          if (ack_rdy) begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg2apb_mst.sv
// Self-checking bench for reg2apb_mst: directed scenarios followed by
// randomized transfers, each checked against an outcome model derived
// from the request and the completer's behaviour.
module tb_reg2apb_mst;

  localparam int AW      = 64;
  localparam int DW      = 32;
  localparam int TIMECNT = 99;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_vld = 1'b0;
  logic          req_rdy;
  logic [AW-1:0] addr = '0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          sync_reset = 1'b0;
  logic          ack_vld;
  logic          ack_rdy = 1'b0;
  logic [DW-1:0] rd_data;
  logic          ack_err;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  int n_compared = 0;
  int n_mismatched = 0;

  reg2apb_mst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMECNT(TIMECNT)) dut (
    .clk(clk), .rstn(rstn),
    .req_vld(req_vld), .req_rdy(req_rdy), .addr(addr), .wr_en(wr_en),
    .rd_en(rd_en), .wr_data(wr_data), .sync_reset(sync_reset),
    .ack_vld(ack_vld), .ack_rdy(ack_rdy), .rd_data(rd_data), .ack_err(ack_err),
    .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reset values, sampled asynchronously or between edges.
  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_psel"}, PSEL, 0);
    check_val({tag, "_penable"}, PENABLE, 0);
    check_val({tag, "_pwrite"}, PWRITE, 0);
    check_val({tag, "_paddr"}, PADDR, 0);
    check_val({tag, "_pwdata"}, PWDATA, 0);
    check_val({tag, "_rd_data"}, rd_data, 0);
    check_val({tag, "_ack_err"}, ack_err, 0);
    check_val({tag, "_req_rdy"}, req_rdy, 1);
    check_val({tag, "_ack_vld"}, ack_vld, 0);
  endtask

  // One transfer, driven and sampled on falling edges. Cycle 0 is the
  // accepting cycle; the expected outcome comes from the request rules:
  // illegal direction -> error, completer wait longer than TIMECNT ->
  // timeout pattern, otherwise PRDATA (reads) / 0 (writes) with PSLVERR.
  task automatic do_txn(input logic we, input logic re, input logic [63:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] prd,
                        input logic serr, input int ack_dly, input int sr_at,
                        input bit rst_resp);
    bit          bad      = (we == re);
    bit          timeout  = !bad && (waits > TIMECNT);
    int          n_access = timeout ? TIMECNT + 1 : waits + 1;
    logic [31:0] exp_data;
    logic        exp_err;
    if (bad)          begin exp_data = 32'h0;          exp_err = 1'b1; end
    else if (timeout) begin exp_data = 32'hdead_1eaf;  exp_err = 1'b1; end
    else              begin exp_data = we ? 32'h0 : prd; exp_err = serr; end

    $display("txn we=%0b re=%0b addr=%0h wd=%0h waits=%0d prd=%0h serr=%0b dly=%0d sr=%0d rst=%0b",
             we, re, a, wd, waits, prd, serr, ack_dly, sr_at, rst_resp);
    check_val("idle_req_rdy", req_rdy, 1);
    req_vld = 1'b1; wr_en = we; rd_en = re; addr = a; wr_data = wd;
    @(negedge clk);
    // Junk on the request port must be ignored outside IDLE.
    req_vld = 1'($urandom); addr = {$urandom, $urandom}; wr_en = 1'($urandom);
    rd_en = 1'($urandom); wr_data = $urandom;
    if (bad) begin
      check_val("bad_no_psel", PSEL, 0);
    end else begin
      check_val("setup_psel", PSEL, 1);
      check_val("setup_penable", PENABLE, 0);
      check_val("setup_paddr", PADDR, a);
      check_val("setup_pwrite", PWRITE, we);
      check_val("setup_pwdata", PWDATA, wd);
      check_val("setup_ack_vld", ack_vld, 0);
      @(negedge clk);
      for (int k = 0; k < n_access; k++) begin
        check_val("access_psel", PSEL, 1);
        check_val("access_penable", PENABLE, 1);
        check_val("access_paddr", PADDR, a);
        check_val("access_pwrite", PWRITE, we);
        check_val("access_pwdata", PWDATA, wd);
        check_val("access_ack_vld", ack_vld, 0);
        if (k == sr_at) begin
          sync_reset = 1'b1; PREADY = 1'b0;
          @(negedge clk);
          sync_reset = 1'b0; req_vld = 1'b0;
          check_val("sr_psel", PSEL, 0);
          check_val("sr_penable", PENABLE, 0);
          check_val("sr_ack_vld", ack_vld, 0);
          check_val("sr_req_rdy", req_rdy, 1);
          return;
        end
        PREADY  = (k == waits);
        PRDATA  = (k == waits) ? prd : $urandom;
        PSLVERR = (k == waits) ? serr : 1'($urandom);
        @(negedge clk);
        PREADY = 1'b0; PSLVERR = 1'b0;
      end
    end
    check_val("resp_ack_vld", ack_vld, 1);
    check_val("resp_psel", PSEL, 0);
    check_val("resp_penable", PENABLE, 0);
    check_val("resp_req_rdy", req_rdy, 0);
    check_val("resp_rd_data", rd_data, exp_data);
    check_val("resp_ack_err", ack_err, exp_err);
    if (rst_resp) begin
      rstn = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      @(negedge clk);
      req_vld = 1'b0;
      rstn = 1'b1;
      return;
    end
    for (int d = 0; d < ack_dly; d++) begin
      ack_rdy = 1'b0;
      @(negedge clk);
      check_val("hold_ack_vld", ack_vld, 1);
      check_val("hold_rd_data", rd_data, exp_data);
      check_val("hold_ack_err", ack_err, exp_err);
      check_val("hold_psel", PSEL, 0);
    end
    ack_rdy = 1'b1; req_vld = 1'b0;
    @(negedge clk);
    ack_rdy = 1'b0;
    check_val("done_ack_vld", ack_vld, 0);
    check_val("done_req_rdy", req_rdy, 1);
    check_val("done_psel", PSEL, 0);
  endtask

  initial begin
    int r, waits, ack_dly, sr_at;
    logic we, re;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rstn = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Directed scenarios.
    do_txn(1'b1, 1'b0, 64'h10, 32'hA5A5_0001, 0, 32'h0, 1'b0, 0, -1, 1'b0);
    do_txn(1'b0, 1'b1, 64'h20, 32'h0, 3, 32'h1234_5678, 1'b0, 2, -1, 1'b0);
    do_txn(1'b0, 1'b1, 64'h30, 32'h0, 1000, 32'h0, 1'b0, 1, -1, 1'b0);
    do_txn(1'b0, 1'b1, 64'h34, 32'h0, TIMECNT, 32'hCAFE_0099, 1'b0, 0, -1, 1'b0);
    do_txn(1'b1, 1'b0, 64'h40, 32'h0BAD_0BAD, 1, 32'h0, 1'b1, 0, -1, 1'b0);
    do_txn(1'b1, 1'b1, 64'h50, 32'h1, 0, 32'h0, 1'b0, 1, -1, 1'b0);
    do_txn(1'b0, 1'b0, 64'h54, 32'h1, 0, 32'h0, 1'b0, 0, -1, 1'b0);
    do_txn(1'b0, 1'b1, 64'h60, 32'h0, 5, 32'h6, 1'b0, 0, 2, 1'b0);
    do_txn(1'b0, 1'b1, 64'h70, 32'h0, 2, 32'h7777_0000, 1'b0, 0, -1, 1'b1);
    do_txn(1'b0, 1'b1, 64'h74, 32'h0, 1, 32'h7777_0001, 1'b0, 0, -1, 1'b0);

    // Randomized transfers.
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom % 20);
      if (r < 14)       waits = int'($urandom % 4);
      else if (r < 16)  waits = TIMECNT;
      else if (r < 17)  waits = TIMECNT + 1;
      else              waits = int'($urandom % 8);
      if ($urandom % 10 == 0) begin we = 1'($urandom); re = we; end
      else begin we = 1'($urandom); re = ~we; end
      ack_dly = int'($urandom % 3);
      sr_at = ($urandom % 12 == 0) ? int'($urandom % 3) : -1;
      do_txn(we, re, {$urandom, $urandom}, $urandom, waits, $urandom,
             1'($urandom), ack_dly, sr_at, ($urandom % 25 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

endmodule

// File: doc/reg2apb_mst.md
REG2APB_MST -- requirements
Module: reg2apb_mst

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 64, address width of the request and APB buses.
REQ-002 SHALL have parameter DATA_WIDTH, 32, data width.
REQ-003 SHALL have parameter TIMECNT, 99, number of ACCESS cycles without PREADY before abort.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 req_vld  input  1  upstream request valid.
REQ-007 req_rdy  output  1  block can accept a request.
REQ-008 addr  input  ADDR_WIDTH  request address.
REQ-009 wr_en  input  1  write request.
REQ-010 rd_en  input  1  read request.
REQ-011 wr_data  input  DATA_WIDTH  write data.
REQ-012 sync_reset  input  1  upstream synchronous abort.
REQ-013 ack_vld  output  1  response valid.
REQ-014 ack_rdy  input  1  upstream accepts response.
REQ-015 rd_data  output  DATA_WIDTH  response read data.
REQ-016 ack_err  output  1  response error flag.
REQ-017 PADDR / PWRITE / PSEL / PENABLE / PWDATA  output  ADDR_WIDTH/1/1/1/DATA_WIDTH  APB3 master request.
REQ-018 PRDATA / PREADY / PSLVERR  input  DATA_WIDTH/1/1  APB3 completer response.

Function
REQ-019 States SHALL be IDLE, SETUP, ACCESS, RESP; req_rdy = (state==IDLE); ack_vld = (state==RESP).
REQ-020 In IDLE, req_vld with exactly one of wr_en/rd_en SHALL latch addr, wr_data, PWRITE=wr_en, then move to SETUP.
REQ-021 In IDLE, req_vld with wr_en==rd_en SHALL go directly to RESP with rd_data=0, ack_err=1; no APB cycle.
REQ-022 SETUP SHALL drive PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
REQ-023 ACCESS SHALL drive PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA stable from SETUP through ACCESS.
REQ-024 ACCESS with PREADY=1 SHALL capture rd_data=PRDATA (reads) or 0 (writes), ack_err=PSLVERR, deassert PSEL/PENABLE, go RESP.
REQ-025 16-bit counter SHALL clear on SETUP entry and increment each ACCESS cycle with PREADY=0; at cnt==TIMECNT, abort: PSEL/PENABLE drop, rd_data=32'hdead_1eaf, ack_err=1, go RESP.
REQ-026 PREADY in the same cycle as cnt==TIMECNT SHALL win (normal completion).
REQ-027 RESP SHALL hold ack_vld, rd_data, ack_err stable until ack_rdy=1, then go IDLE; req_vld ignored outside IDLE.
REQ-028 Minimum latency: request accepted cycle 0, PSEL cycle 1, PENABLE cycle 2, PREADY sampled cycle 2, ack_vld cycle 3.
REQ-029 sync_reset=1 in any state SHALL force IDLE next cycle, deassert PSEL/PENABLE/ack_vld, clear counter; it overrides all other transitions.
REQ-030 PSEL, PENABLE, PADDR, PWRITE, PWDATA, rd_data, ack_err SHALL be registered outputs.

Reset
REQ-031 On rstn low: state IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rd_data=0, ack_err=0, counter 0; req_rdy=1, ack_vld=0.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer with no response produced.

Structure
REQ-033 State encoding (2-bit), the 32'hdead_1eaf timeout pattern and the default TIMECNT SHALL live in the shared register-interface package.
REQ-034 Single flat module; no sub-module is required.

Verification
REQ-035 Write addr=0x10, data=0xA5A5_0001, PREADY immediate -> PSEL cycles 1-2, PENABLE cycle 2, ack_vld cycle 3, ack_err=0.
REQ-036 Read addr=0x20, PREADY after 3 wait states, PRDATA=0x1234_5678 -> rd_data=0x1234_5678, ack_vld held 2 cycles while ack_rdy=0.
REQ-037 Read with PREADY never asserted -> abort after TIMECNT ACCESS cycles, rd_data=0xdead_1eaf, ack_err=1.
REQ-038 Write with PSLVERR=1 on PREADY -> ack_err=1; req_vld with wr_en=rd_en=1 -> immediate ack_err=1, no PSEL.
REQ-039 sync_reset pulsed during ACCESS -> PSEL/PENABLE 0 next cycle, no ack_vld, req_rdy=1.
REQ-040 rstn asserted during RESP -> all outputs at reset values asynchronously; next request completes normally.
